multicycle_control_unit: RTL and testbench

Moore-style main controller that sequences the multi-cycle MIPS datapath: fetch, decode, execute, memory and writeback. It consumes the opcode produced by `decode_stage` and drives every mux select, write enable and ALU-op line for one instruction at a time. Memory accesses are stretched by a `mem_ready` handshake, so the same controller works with single-cycle or wait-stated memory.

---
 rtl/multicycle_control_unit_pkg.sv | 68 ++++++
 rtl/multicycle_control_unit_if.sv | 36 +++
 rtl/multicycle_control_unit_decoder.sv | 71 +++++++
 rtl/multicycle_control_unit.sv | 88 ++++++++
 tb/tb_multicycle_control_unit.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared constants and types for the multi-cycle MIPS main controller:
// opcodes, FSM state encodings, datapath select codes and the bundled
// control vector passed from the output decoder to the top.
package multicycle_control_unit_pkg;

    // Opcodes understood by the controller (shared with decode_stage).
    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] J     = 6'b000010;
    localparam logic [5:0] ADDI  = 6'b001000;

    // FSM states; the 4-bit encoding is visible on the debug state port.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_e;

    // ALU B-operand select.
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // ALU operation class.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Next-PC source.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Every datapath control line driven by the controller.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic opcode_known(input logic [5:0] op);
        return (op == RTYPE) || (op == LW) || (op == SW) ||
               (op == BEQ)   || (op == J)  || (op == ADDI);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Controller <-> datapath bundle: opcode and memory handshake in,
// all mux selects / write enables / debug state out.
// master = controller side, slave = datapath (or bench) side.
interface multicycle_control_unit_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       illegal_opcode;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal_opcode
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal_opcode
    );
endinterface

// File: rtl/multicycle_control_unit_decoder.sv
// Purpose: combinational map of controller state (+ mem_ready) to control vector.
// Ports:   state, mem_ready in; ctrl (packed ctrl_t) out.
// Latency: zero (pure combinational); mem_ready only gates ir_write/pc_write in FETCH.
module control_output_decoder
    import multicycle_control_unit_pkg::*;
(
    input  state_e state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // Only commit PC+4 and the instruction word once the read lands,
                // so a wait-stated fetch updates them exactly once.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Purpose: Moore main controller sequencing fetch/decode/execute/memory/writeback.
// Ports:   clock, reset (async, active-high); bus (master modport) carries opcode,
//          mem_ready in and all datapath controls, debug state, illegal_opcode out.
// Latency: LW 5, SW/R/ADDI 4, BEQ/J 3, illegal 2 cycles; +1 per mem_ready=0 in
//          FETCH/MEM_RD/MEM_WR (state holds, access strobes stay asserted).
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    multicycle_control_unit_if.master   bus
);

    state_e     state_q;
    state_e     state_d;
    logic [5:0] opcode_q;
    ctrl_t      ctrl;
    ctrl_t      ctrl_out;
    logic       illegal;

    // Next-state logic.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    LW, SW:  state_d = S_MEM_ADDR;
                    RTYPE:   state_d = S_EXEC;
                    BEQ:     state_d = S_BRANCH;
                    J:       state_d = S_JUMP;
                    ADDI:    state_d = S_ADDI_EX;
                    default: state_d = S_FETCH;
                endcase
            end
            // The live opcode bus may already carry the next word; use the latch.
            S_MEM_ADDR: state_d = (opcode_q == LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   state_d = bus.mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC:     state_d = S_R_WB;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                opcode_q <= bus.opcode;
            end
        end
    end

    control_output_decoder u_decoder (
        .state     (state_q),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    // Only the DECODE state looks at the opcode, so unused state encodings
    // can never raise this flag.
    assign illegal = (state_q == S_DECODE) && !opcode_known(bus.opcode);

    // Reset kills every output combinationally, so no write enable can
    // glitch high in the cycle reset is raised.
    assign ctrl_out = reset ? '0 : ctrl;

    assign bus.pc_write       = ctrl_out.pc_write;
    assign bus.pc_write_cond  = ctrl_out.pc_write_cond;
    assign bus.i_or_d         = ctrl_out.i_or_d;
    assign bus.mem_read       = ctrl_out.mem_read;
    assign bus.mem_write      = ctrl_out.mem_write;
    assign bus.ir_write       = ctrl_out.ir_write;
    assign bus.mem_to_reg     = ctrl_out.mem_to_reg;
    assign bus.reg_dst        = ctrl_out.reg_dst;
    assign bus.reg_write      = ctrl_out.reg_write;
    assign bus.alu_src_a      = ctrl_out.alu_src_a;
    assign bus.alu_src_b      = ctrl_out.alu_src_b;
    assign bus.alu_op         = ctrl_out.alu_op;
    assign bus.pc_source      = ctrl_out.pc_source;
    assign bus.state          = reset ? 4'd0 : state_q;
    assign bus.illegal_opcode = illegal && !reset;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: table of instructions with wait-state
// patterns and hand-derived latencies, hand-written reset sequences, and a
// random instruction stream checked against a per-instruction phase model.
module tb_multicycle_control_unit;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic clock;
    logic reset;
    int   tests;
    int   fails;

    multicycle_control_unit_if bus ();

    multicycle_control_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [5:0] op;
        int         fw;
        int         mw;
        int         cyc;
    } vec_t;

    // Phase plan for one instruction (state numbers as listed in the spec).
    int ph[6];
    int nph;

    function automatic logic known(input logic [5:0] op);
        return op == OP_R || op == OP_LW || op == OP_SW ||
               op == OP_BEQ || op == OP_J || op == OP_ADDI;
    endfunction

    function automatic void plan(input logic [5:0] op);
        ph[0] = 0;
        ph[1] = 1;
        nph   = 2;
        case (op)
            OP_LW:   begin ph[2] = 2;  ph[3] = 3;  ph[4] = 4; nph = 5; end
            OP_SW:   begin ph[2] = 2;  ph[3] = 5;  nph = 4; end
            OP_R:    begin ph[2] = 6;  ph[3] = 7;  nph = 4; end
            OP_ADDI: begin ph[2] = 10; ph[3] = 11; nph = 4; end
            OP_BEQ:  begin ph[2] = 8;  nph = 3; end
            OP_J:    begin ph[2] = 9;  nph = 3; end
            default: nph = 2;
        endcase
    endfunction

    // Cycle count FETCH->FETCH with no wait states.
    function automatic int base_latency(input logic [5:0] op);
        case (op)
            OP_LW:                 return 5;
            OP_SW, OP_R, OP_ADDI:  return 4;
            OP_BEQ, OP_J:          return 3;
            default:               return 2;
        endcase
    endfunction

    // Expected output vector {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
    // ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
    // pc_source, illegal_opcode} for a given state.
    function automatic logic [16:0] exp_out(input int st, input logic rdy, input logic ill);
        logic pw, pwc, iod, mr, mw, irw, mtr, rd, rw, asa;
        logic [1:0] sb, op, ps;
        {pw, pwc, iod, mr, mw, irw, mtr, rd, rw, asa} = '0;
        sb = 2'b00; op = 2'b00; ps = 2'b00;
        case (st)
            0:      begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
            1:      sb = 2'b11;
            2, 10:  begin asa = 1; sb = 2'b10; end
            3:      begin mr = 1; iod = 1; end
            4:      begin rw = 1; mtr = 1; end
            5:      begin mw = 1; iod = 1; end
            6:      begin asa = 1; op = 2'b10; end
            7:      begin rw = 1; rd = 1; end
            8:      begin asa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
            9:      begin pw = 1; ps = 2'b10; end
            11:     rw = 1;
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, mtr, rd, rw, asa, sb, op, ps, ill};
    endfunction

    function automatic logic [16:0] act_out();
        return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal_opcode};
    endfunction

    task automatic check_vals(input string name, input int exp_st, input logic [16:0] exp_v);
        tests++;
        if (int'(bus.state) != exp_st) begin
            fails++;
            $display("FAIL %s state: got %0d expected %0d (t=%0t)", name, bus.state, exp_st, $time);
        end
        tests++;
        if (act_out() !== exp_v) begin
            fails++;
            $display("FAIL %s outputs in state %0d: got %b expected %b (t=%0t)",
                     name, exp_st, act_out(), exp_v, $time);
        end
    endtask

    // Drive one cycle's inputs at the negedge, check #1 later, advance a cycle.
    task automatic step(input string name, input int st, input logic [5:0] op, input logic rdy);
        logic ill;
        bus.mem_ready = rdy;
        bus.opcode    = (st == 1) ? op : 6'($urandom);
        ill = (st == 1) && !known(op);
        #1;
        check_vals(name, st, exp_out(st, rdy, ill));
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic run_instr(input string name, input logic [5:0] op, input int fw,
                             input int mwt, output int cycles);
        plan(op);
        cycles = 0;
        for (int p = 0; p < nph; p++) begin
            int  waits;
            bit  waitable;
            waitable = (ph[p] == 0) || (ph[p] == 3) || (ph[p] == 5);
            waits    = (ph[p] == 0) ? fw : (waitable ? mwt : 0);
            for (int w = 0; w <= waits; w++) begin
                logic rdy;
                rdy = waitable ? (w == waits) : 1'($urandom_range(0, 1));
                step(name, ph[p], op, rdy);
                cycles++;
            end
        end
    endtask

    task automatic check_latency(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s latency: got %0d expected %0d", name, got, exp);
        end
    endtask

    vec_t tbl[12];
    logic [5:0] rop_list[8];

    initial begin
        int cyc;
        tests = 0;
        fails = 0;

        tbl[0]  = '{OP_LW,        0, 0, 5};
        tbl[1]  = '{OP_SW,        0, 0, 4};
        tbl[2]  = '{OP_R,         0, 0, 4};
        tbl[3]  = '{OP_BEQ,       0, 0, 3};
        tbl[4]  = '{OP_J,         0, 0, 3};
        tbl[5]  = '{OP_ADDI,      0, 0, 4};
        tbl[6]  = '{6'b111111,    0, 0, 2};
        tbl[7]  = '{OP_SW,        0, 2, 6};
        tbl[8]  = '{OP_R,         4, 0, 8};
        tbl[9]  = '{OP_LW,        1, 3, 9};
        tbl[10] = '{6'b010101,    2, 3, 4};
        tbl[11] = '{OP_ADDI,      0, 3, 4};

        rop_list[0] = OP_R;   rop_list[1] = OP_LW; rop_list[2] = OP_SW;
        rop_list[3] = OP_BEQ; rop_list[4] = OP_J;  rop_list[5] = OP_ADDI;
        rop_list[6] = 6'b111111; rop_list[7] = 6'b001111;

        // Reset held 3 cycles with LW and mem_ready presented: everything stays 0.
        reset         = 1'b1;
        bus.opcode    = OP_LW;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            check_vals("reset_hold", 0, 17'd0);
        end
        @(negedge clock);
        reset = 1'b0;
        run_instr("post_reset_lw", OP_LW, 0, 0, cyc);
        check_latency("post_reset_lw", cyc, 5);

        // Table of instructions and wait-state patterns.
        for (int i = 0; i < 12; i++) begin
            run_instr($sformatf("tbl%0d", i), tbl[i].op, tbl[i].fw, tbl[i].mw, cyc);
            check_latency($sformatf("tbl%0d", i), cyc, tbl[i].cyc);
        end

        // Async reset mid-cycle while waiting in MEM_RD.
        step("arst_fetch", 0, OP_LW, 1'b1);
        step("arst_decode", 1, OP_LW, 1'b1);
        step("arst_addr", 2, OP_LW, 1'b1);
        bus.mem_ready = 1'b0;
        #1;
        check_vals("arst_memrd", 3, exp_out(3, 1'b0, 1'b0));
        #2;
        reset = 1'b1;
        #1;
        check_vals("arst_applied", 0, 17'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        run_instr("arst_next_j", OP_J, 0, 0, cyc);
        check_latency("arst_next_j", cyc, 3);

        // Random instruction stream vs. latency arithmetic and phase model.
        for (int i = 0; i < 40; i++) begin
            logic [5:0] op;
            int fw, mwt, exp_c;
            op    = rop_list[$urandom_range(0, 7)];
            fw    = $urandom_range(0, 3);
            mwt   = $urandom_range(0, 3);
            exp_c = base_latency(op) + fw + ((op == OP_LW || op == OP_SW) ? mwt : 0);
            run_instr($sformatf("rnd%0d", i), op, fw, mwt, cyc);
            check_latency($sformatf("rnd%0d", i), cyc, exp_c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
